// File: rtl/fdd_mfm_tx_pkg.sv
// Shared constants and types for the MFM read-data pulse generator.
package fdd_mfm_tx_pkg;
    localparam int CELL_CLKS_DEF  = 56;
    localparam int PULSE_CLKS_DEF = 8;

    typedef enum logic [1:0] {
        MARK_NONE = 2'b00,
        MARK_A1   = 2'b01,
        MARK_C2   = 2'b10
    } mark_e;

    localparam logic [7:0] GAP_BYTE = 8'h4E;
    localparam int A1_MISSING_BIT   = 5;
    localparam int C2_MISSING_BIT   = 7;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] mark;
    } hold_t;
endpackage

// File: rtl/fdd_mfm_tx_mfm_encode.sv
// Pure combinational MFM encoder: one byte plus the previous data bit to a
// 16-cell codeword, c7 in bit 15 down to d0 in bit 0.
module mfm_encode
    import fdd_mfm_tx_pkg::*;
(
    input  logic [7:0]  data,
    input  logic        prev,
    input  logic [1:0]  mark,
    output logic [15:0] cw
);
    logic [8:0] ext;

    always_comb begin
        ext = {prev, data};
        cw  = '0;
        for (int i = 0; i < 8; i++) begin
            cw[2*i]   = ext[i];
            cw[2*i+1] = ~(ext[i+1] | ext[i]);
        end
        // Sync marks drop one clock pulse so they cannot occur in normal data.
        if (mark == MARK_A1) begin
            cw[A1_MISSING_BIT] = 1'b0;
        end else if (mark == MARK_C2) begin
            cw[C2_MISSING_BIT] = 1'b0;
        end
    end
endmodule

// File: rtl/fdd_mfm_tx.sv
// Floppy read-data emulator: serialises bytes as MFM cells and emits an
// active-low pulse at the start of every 1 cell.
module fdd_mfm_tx
    import fdd_mfm_tx_pkg::*;
#(
    parameter int CELL_CLKS  = CELL_CLKS_DEF,
    parameter int PULSE_CLKS = PULSE_CLKS_DEF
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] din,
    input  logic [1:0] din_mark,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       rdat_n,
    output logic       byte_strobe,
    output logic       underrun,
    output logic       busy
);
    localparam int CNT_W = $clog2(CELL_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CELL_CLKS - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CLKS);

    logic             ena_q, ena_d;
    hold_t            hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [15:0]      shift_q, shift_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             rdat_n_q, rdat_n_d;
    logic             din_ready_q, din_ready_d;
    logic             byte_strobe_q, byte_strobe_d;
    logic             underrun_q, underrun_d;

    logic [7:0]  enc_data;
    logic [1:0]  enc_mark;
    logic [15:0] enc_cw;
    logic        accept, boundary, load, bnd_next;

    assign enc_data = hold_full_q ? hold_q.data : GAP_BYTE;
    assign enc_mark = hold_full_q ? hold_q.mark : MARK_NONE;

    mfm_encode u_enc (
        .data (enc_data),
        .prev (prev_q),
        .mark (enc_mark),
        .cw   (enc_cw)
    );

    always_comb begin
        accept   = din_valid & din_ready_q;
        boundary = ena_q & (idx_q == 4'd15) & (cnt_q == CNT_LAST);
        load     = ena & (~ena_q | boundary);

        ena_d         = ena;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        shift_d       = shift_q;
        prev_d        = prev_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        rdat_n_d      = 1'b1;
        byte_strobe_d = 1'b0;
        underrun_d    = 1'b0;

        if (!ena) begin
            hold_d      = '0;
            hold_full_d = 1'b0;
            shift_d     = '0;
            prev_d      = 1'b0;
            cnt_d       = '0;
            idx_d       = '0;
        end else begin
            if (load) begin
                shift_d       = enc_cw;
                prev_d        = enc_data[0];
                cnt_d         = '0;
                idx_d         = '0;
                hold_full_d   = 1'b0;
                byte_strobe_d = 1'b1;
                underrun_d    = ~hold_full_q;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                idx_d   = idx_q + 4'd1;
                shift_d = {shift_q[14:0], 1'b0};
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // A byte taken on the boundary edge lands in holding while the
            // previously held byte moves into the shifter.
            if (accept) begin
                hold_d      = '{data: din, mark: din_mark};
                hold_full_d = 1'b1;
            end
            rdat_n_d = ~(shift_q[15] & (cnt_q < PULSE_END));
        end

        // Ready looks one cycle ahead so a full holding register can still
        // take a byte on the edge that empties it.
        bnd_next    = (idx_d == 4'd15) & (cnt_d == CNT_LAST);
        din_ready_d = ena & (~hold_full_d | bnd_next);
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            ena_q         <= 1'b0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            shift_q       <= '0;
            prev_q        <= 1'b0;
            cnt_q         <= '0;
            idx_q         <= '0;
            rdat_n_q      <= 1'b1;
            din_ready_q   <= 1'b0;
            byte_strobe_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            ena_q         <= ena_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            shift_q       <= shift_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            rdat_n_q      <= rdat_n_d;
            din_ready_q   <= din_ready_d;
            byte_strobe_q <= byte_strobe_d;
            underrun_q    <= underrun_d;
        end
    end

    assign din_ready   = din_ready_q;
    assign rdat_n      = rdat_n_q;
    assign byte_strobe = byte_strobe_q;
    assign underrun    = underrun_q;
    assign busy        = ena_q;
endmodule

// File: tb/tb_fdd_mfm_tx.sv
// Scoreboard bench: stimulus queues expected codewords, a monitor rebuilds
// each transmitted byte from the rdat_n pulse train and compares.
module tb_fdd_mfm_tx;
    localparam int CELL      = 56;
    localparam int PULSE     = 8;
    localparam int BYTE_CLKS = 16 * CELL;

    typedef struct packed {
        logic [15:0] cw;
        logic        und;
    } exp_t;

    logic       fclk, rst_n, ena, din_valid;
    logic [7:0] din;
    logic [1:0] din_mark;
    logic       din_ready, rdat_n, byte_strobe, underrun, busy;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    fdd_mfm_tx #(.CELL_CLKS(CELL), .PULSE_CLKS(PULSE)) dut (
        .fclk        (fclk),
        .rst_n       (rst_n),
        .ena         (ena),
        .din         (din),
        .din_mark    (din_mark),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .rdat_n      (rdat_n),
        .byte_strobe (byte_strobe),
        .underrun    (underrun),
        .busy        (busy)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic chk_b(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    int   pos = -1;
    int   lowcnt[16];
    int   cyc = 0;
    int   last_strobe = 0;
    bit   last_ok = 1'b0;
    logic cur_und = 1'b0;
    logic [15:0] w;
    int   bad;
    exp_t e;

    always @(negedge fclk) begin
        cyc++;
        if (pos >= 0 && !busy) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            pos = -1;
        end
        if (!busy) last_ok = 1'b0;
        if (pos >= 0) begin
            if (!rdat_n) lowcnt[pos / CELL]++;
            pos++;
            if (pos == BYTE_CLKS) begin
                w   = '0;
                bad = 0;
                for (int j = 0; j < 16; j++) begin
                    w = {w[14:0], lowcnt[j] == PULSE};
                    if (lowcnt[j] != 0 && lowcnt[j] != PULSE) bad++;
                end
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_byte: got 0x%04h want no byte", w);
                end else begin
                    e = sb_q.pop_front();
                    chk_w("codeword", 32'(w), 32'(e.cw));
                    chk_b("underrun_flag", cur_und, e.und);
                    chk_w("pulse_shape", 32'(bad), 32'd0);
                end
                pos = -1;
            end
        end
        if (byte_strobe) begin
            if (last_ok) chk_w("strobe_spacing", 32'(cyc - last_strobe), 32'(BYTE_CLKS));
            last_strobe = cyc;
            last_ok     = 1'b1;
            pos         = 0;
            cur_und     = underrun;
            for (int j = 0; j < 16; j++) lowcnt[j] = 0;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return din_ready;
            1:       return underrun;
            2:       return byte_strobe;
            default: return rdat_n;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic lvl, input string name, input int bound);
        int n = 0;
        while (sig_of(sel) !== lvl && n < bound) begin
            @(negedge fclk);
            n++;
        end
        if (sig_of(sel) !== lvl) begin
            tests++;
            fails++;
            $display("FAIL timeout_%s: got no level %b after %0d cycles", name, lvl, n);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [1:0] m, input logic [15:0] cw);
        din       = b;
        din_mark  = m;
        din_valid = 1'b1;
        wait_sig(0, 1'b1, "din_ready", 4000);
        @(posedge fclk);
        sb_q.push_back('{cw: cw, und: 1'b0});
        #1;
        din_valid = 1'b0;
    endtask

    logic [7:0]  s_byte[6] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01};
    logic [15:0] s_cw[6]   = '{16'hAAAA, 16'hAAAA, 16'h5555, 16'h5555, 16'h2AAA, 16'hAAA9};
    longint      acc_t[6];
    int          coincide = 0;

    initial begin
        rst_n = 1'b0; ena = 1'b0; din = '0; din_mark = '0; din_valid = 1'b0;
        repeat (3) @(negedge fclk);
        chk_b("rst_rdat_n", rdat_n, 1'b1);
        chk_b("rst_din_ready", din_ready, 1'b0);
        chk_b("rst_byte_strobe", byte_strobe, 1'b0);
        chk_b("rst_underrun", underrun, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge fclk);
        chk_b("idle_busy", busy, 1'b0);
        chk_b("idle_din_ready", din_ready, 1'b0);
        chk_b("idle_rdat_n", rdat_n, 1'b1);

        // Start: the holding register is always empty, so a gap byte goes first.
        sb_q.push_back('{cw: 16'h9254, und: 1'b1});
        ena = 1'b1;
        send(8'h00, 2'b00, 16'hAAAA);
        send(8'h00, 2'b11, 16'hAAAA);
        send(8'hA1, 2'b01, 16'h4489);
        send(8'hC2, 2'b10, 16'h5224);
        send(8'hFF, 2'b00, 16'h5555);
        sb_q.push_back('{cw: 16'h1254, und: 1'b1});
        wait_sig(1, 1'b1, "underrun", 4000);
        send(8'h01, 2'b00, 16'hAAA9);

        // Drop ena in the middle of the first pulse of 0xAAA9.
        wait_sig(2, 1'b1, "byte_strobe", 4000);
        wait_sig(3, 1'b0, "rdat_low", 200);
        repeat (4) @(negedge fclk);
        chk_b("pulse_in_progress", rdat_n, 1'b0);
        ena = 1'b0;
        @(posedge fclk); #1;
        chk_b("drop_rdat_n", rdat_n, 1'b1);
        chk_b("drop_din_ready", din_ready, 1'b0);
        chk_b("drop_busy", busy, 1'b0);
        chk_b("drop_byte_strobe", byte_strobe, 1'b0);

        repeat (20) @(negedge fclk);
        sb_q.push_back('{cw: 16'h9254, und: 1'b1});
        ena = 1'b1;
        @(posedge fclk); #1;
        chk_b("restart_strobe", byte_strobe, 1'b1);
        chk_b("restart_underrun", underrun, 1'b1);
        chk_b("restart_busy", busy, 1'b1);
        chk_b("restart_first_cell_latency", rdat_n, 1'b1);
        chk_b("restart_din_ready", din_ready, 1'b1);
        @(posedge fclk); #1;
        chk_b("restart_cell0_pulse", rdat_n, 1'b0);

        // Continuous valid: one byte taken per byte time.
        din_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din      = s_byte[i];
            din_mark = 2'b00;
            wait_sig(0, 1'b1, "stream_ready", 4000);
            @(posedge fclk);
            sb_q.push_back('{cw: s_cw[i], und: 1'b0});
            acc_t[i] = $time;
            #1;
            if (byte_strobe) coincide++;
        end
        din_valid = 1'b0;
        for (int i = 2; i < 6; i++)
            chk_w("accept_spacing", 32'((acc_t[i] - acc_t[i-1]) / 10), 32'(BYTE_CLKS));
        chk_w("accept_load_coincide", 32'(coincide), 32'd5);

        sb_q.push_back('{cw: 16'h1254, und: 1'b1});
        sb_q.push_back('{cw: 16'h9254, und: 1'b1});
        begin
            int n = 0;
            while (sb_q.size() > 1 && n < 4000) begin
                @(negedge fclk);
                n++;
            end
            if (sb_q.size() > 1) begin
                tests++;
                fails++;
                $display("FAIL timeout_drain: got %0d queued want 1", sb_q.size());
            end
        end

        // Asynchronous reset in the middle of a pulse.
        wait_sig(3, 1'b0, "rdat_low_rst", 200);
        #2;
        rst_n = 1'b0;
        #1;
        chk_b("async_rst_rdat_n", rdat_n, 1'b1);
        chk_b("async_rst_din_ready", din_ready, 1'b0);
        chk_b("async_rst_byte_strobe", byte_strobe, 1'b0);
        chk_b("async_rst_underrun", underrun, 1'b0);
        chk_b("async_rst_busy", busy, 1'b0);
        ena = 1'b0;
        repeat (3) @(negedge fclk);
        rst_n = 1'b1;
        repeat (5) @(negedge fclk);
        chk_b("post_rst_idle", busy, 1'b0);
        chk_w("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish within 200000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
